// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pin and key-event signal bundle for keypad_scanner
// master = scanner side, slave = board/consumer side.
interface keypad_scanner_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

   logic [ROWS-1:0]   rows;
   logic [COLS-1:0]   columns;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_pressed;

   modport master (
      input  rows,
      output columns,
      output key_code,
      output key_valid,
      output key_pressed
   );

   modport slave (
      output rows,
      input  columns,
      input  key_code,
      input  key_valid,
      input  key_pressed
   );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - matrix keypad scanner with press/release debounce and key events
// Optional auto-repeat of the held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int REPEAT_DELAY    = 5000000,
   parameter int REPEAT_RATE     = 1000000
) (
   input  logic                 clock,
   input  logic                 resetn,
   keypad_scanner_if.master     kp
);
   localparam int CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
   localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW     = $clog2(SCAN_DIV);
   localparam int DBW    = $clog2(DEBOUNCE_CYCLES + 1);

   if (ROWS < 1 || COLS < 1 || SCAN_DIV < 3 || DEBOUNCE_CYCLES < 1 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("keypad_scanner: illegal parameter value");
   end

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d, col_adv;
   logic [COLS-1:0]   columns_q, columns_d;
   logic [DW-1:0]     div_q, div_d;
   logic [DBW-1:0]    cnt_q, cnt_d;
   logic [RW-1:0]     row_q, row_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              pressed_q, pressed_d;
   logic [ROWS-1:0]   rs1_q, rs_q;
   logic              any_low;
   logic [RW-1:0]     low_idx;
   logic              rs_sel;
   logic              release_hit;
`ifdef KEYPAD_REPEAT_EN
   logic [31:0]       rep_q, rep_d;
   logic              rep_first_q, rep_first_d;
`endif

   // Lowest-index closed row wins when several keys share the driven column.
   always_comb begin
      any_low = 1'b0;
      low_idx = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rs_q[i]) begin
            any_low = 1'b1;
            low_idx = RW'(i);
         end
      end
   end

   assign col_adv     = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
   assign rs_sel      = rs_q[row_q];
   assign release_hit = (state_q == ST_HELD) && rs_sel &&
                        (cnt_q == DBW'(DEBOUNCE_CYCLES - 1));

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      div_d     = div_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      pressed_d = pressed_q;
`ifdef KEYPAD_REPEAT_EN
      rep_d       = '0;
      rep_first_d = 1'b1;
`endif
      case (state_q)
         ST_SCAN: begin
            if (div_q == DW'(SCAN_DIV - 1)) begin
               div_d = '0;
               if (any_low) begin
                  row_d   = low_idx;
                  cnt_d   = '0;
                  state_d = ST_DEBOUNCE;
               end else begin
                  col_d = col_adv;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (rs_sel) begin
               state_d = ST_SCAN;
               col_d   = col_adv;
               cnt_d   = '0;
            end else if (cnt_q == DBW'(DEBOUNCE_CYCLES)) begin
               state_d   = ST_HELD;
               code_d    = CODE_W'(col_q) * CODE_W'(ROWS) + CODE_W'(row_q);
               valid_d   = 1'b1;
               pressed_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (!rs_sel) begin
               cnt_d = '0;
            end else if (release_hit) begin
               pressed_d = 1'b0;
               state_d   = ST_SCAN;
               col_d     = col_adv;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`ifdef KEYPAD_REPEAT_EN
            // A release completing this cycle suppresses any repeat pulse.
            if (!release_hit) begin
               rep_first_d = rep_first_q;
               if (rep_q == (rep_first_q ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_RATE - 1))) begin
                  valid_d     = 1'b1;
                  rep_d       = '0;
                  rep_first_d = 1'b0;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
`endif
         end
         default: begin
            state_d = ST_SCAN;
         end
      endcase
      columns_d = ~(COLS'(1) << col_d);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q   <= ST_SCAN;
         col_q     <= '0;
         columns_q <= ~COLS'(1);
         div_q     <= '0;
         cnt_q     <= '0;
         row_q     <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         pressed_q <= 1'b0;
         rs1_q     <= '1;
         rs_q      <= '1;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= '0;
         rep_first_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         columns_q <= columns_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         pressed_q <= pressed_d;
         rs1_q     <= kp.rows;
         rs_q      <= rs1_q;
`ifdef KEYPAD_REPEAT_EN
         rep_q       <= rep_d;
         rep_first_q <= rep_first_d;
`endif
      end
   end

   assign kp.columns     = columns_q;
   assign kp.key_code    = code_q;
   assign kp.key_valid   = valid_q;
   assign kp.key_pressed = pressed_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner (4x4, fast scan/debounce)
module tb_keypad_scanner;
   localparam int ROWS = 4;
   localparam int COLS = 4;

   typedef struct {
      int         col;
      int         row;
      logic [3:0] exp_code;
   } vec_t;

   logic clock = 1'b0;
   logic resetn;
   logic [COLS-1:0][ROWS-1:0] keys;
   int checks = 0;
   int errors = 0;
   vec_t vecs [7];

   always #5 clock = ~clock;

   keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

   keypad_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
      .REPEAT_DELAY(40), .REPEAT_RATE(10)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .kp    (kp)
   );

   // Passive switch matrix: a closed key pulls its row low while its column is driven.
   always_comb begin
      kp.rows = '1;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (keys[c][r] && !kp.columns[c]) kp.rows[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wait_valid(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (kp.key_valid) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_release(input int budget, output bit done);
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!kp.key_pressed) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (kp.key_valid) cnt++;
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_cols"},    32'(kp.columns),     32'hE);
      check({name, "_code"},    32'(kp.key_code),    32'h0);
      check({name, "_valid"},   32'(kp.key_valid),   32'h0);
      check({name, "_pressed"}, 32'(kp.key_pressed), 32'h0);
   endtask

   initial begin
      bit         ok;
      int         cnt;
      logic [3:0] exp_cols;
      logic [3:0] one4;
      logic       seen;
      logic       exp_v;
      bit         rep_en;

      vecs[0] = '{2, 1, 4'd9};
      vecs[1] = '{0, 0, 4'd0};
      vecs[2] = '{3, 3, 4'd15};
      vecs[3] = '{1, 2, 4'd6};
      vecs[4] = '{0, 3, 4'd3};
      vecs[5] = '{3, 0, 4'd12};
      vecs[6] = '{1, 1, 4'd5};
`ifdef KEYPAD_REPEAT_EN
      rep_en = 1'b1;
`else
      rep_en = 1'b0;
`endif
      one4   = 4'b0001;
      keys   = '0;
      resetn = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");

      // Idle scan: E,D,B,7 each held four cycles.
      resetn = 1'b1;
      seen   = 1'b0;
      for (int k = 0; k < 32; k++) begin
         tick();
         exp_cols = ~(one4 << (((k + 1) / 4) % 4));
         check("idle_cols", 32'(kp.columns), 32'(exp_cols));
         seen |= kp.key_valid;
      end
      check("idle_no_valid", 32'(seen), 32'h0);

      // Key col 2 row 1 held from reset: exact event and release timing.
      resetn = 1'b0;
      keys[2][1] = 1'b1;
      repeat (2) tick();
      resetn = 1'b1;
      for (int k = 0; k <= 21; k++) begin
         tick();
         if (k == 19) check("lat_before", 32'(kp.key_valid), 32'h0);
         if (k == 20) begin
            check("lat_valid",   32'(kp.key_valid),   32'h1);
            check("lat_code",    32'(kp.key_code),    32'd9);
            check("lat_pressed", 32'(kp.key_pressed), 32'h1);
            check("lat_cols",    32'(kp.columns),     32'hB);
         end
         if (k == 21) check("lat_one_pulse", 32'(kp.key_valid), 32'h0);
      end
      keys[2][1] = 1'b0;
      for (int m = 1; m <= 10; m++) begin
         tick();
         if (m == 9) check("rel_still_held", 32'(kp.key_pressed), 32'h1);
         if (m == 10) begin
            check("rel_dropped", 32'(kp.key_pressed), 32'h0);
            check("rel_col_adv", 32'(kp.columns),     32'h7);
         end
      end

      // Table of single key presses.
      for (int i = 0; i < 7; i++) begin
         keys = '0;
         keys[vecs[i].col][vecs[i].row] = 1'b1;
         wait_valid(200, ok);
         check("vec_event",   32'(ok),             32'h1);
         check("vec_code",    32'(kp.key_code),    32'(vecs[i].exp_code));
         check("vec_pressed", 32'(kp.key_pressed), 32'h1);
         count_valid(20, cnt);
         check("vec_single",  32'(cnt), 32'h0);
         keys = '0;
         wait_release(50, ok);
         check("vec_release", 32'(ok), 32'h1);
         repeat (3) tick();
      end

      // Bouncing contact on col 3 row 3.
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (kp.columns == 4'h7) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("bounce_col_found", 32'(ok), 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         keys[3][3] = (i % 2 == 0);
         tick();
         seen |= kp.key_valid;
      end
      keys[3][3] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen |= kp.key_valid;
      end
      check("bounce_no_event", 32'(seen), 32'h0);
      wait_valid(200, ok);
      check("bounce_event", 32'(ok),          32'h1);
      check("bounce_code",  32'(kp.key_code), 32'd15);
      count_valid(20, cnt);
      check("bounce_single", 32'(cnt), 32'h0);
      keys = '0;
      wait_release(50, ok);
      check("bounce_release", 32'(ok), 32'h1);

      // Multiple keys: 5 held, then 6 and 1 added.
      keys[1][1] = 1'b1;
      wait_valid(200, ok);
      check("multi_first", 32'(ok),          32'h1);
      check("multi_code5", 32'(kp.key_code), 32'd5);
      keys[1][2] = 1'b1;
      keys[0][1] = 1'b1;
      count_valid(60, cnt);
      check("multi_ignored", 32'(cnt),            32'h0);
      check("multi_held",    32'(kp.key_pressed), 32'h1);
      keys[1][1] = 1'b0;
      wait_valid(200, ok);
      check("multi_next",  32'(ok),          32'h1);
      check("multi_code1", 32'(kp.key_code), 32'd1);
      keys[0][1] = 1'b0;
      wait_valid(200, ok);
      check("multi_last",  32'(ok),          32'h1);
      check("multi_code6", 32'(kp.key_code), 32'd6);
      keys = '0;
      wait_release(50, ok);
      check("multi_release", 32'(ok), 32'h1);

      // Reset during DEBOUNCE, then during HELD.
      resetn = 1'b0;
      keys[2][1] = 1'b1;
      repeat (2) tick();
      resetn = 1'b1;
      seen = 1'b0;
      for (int k = 0; k <= 14; k++) begin
         tick();
         seen |= kp.key_valid;
      end
      resetn = 1'b0;
      tick();
      check_reset_outputs("rst_deb");
      for (int i = 0; i < 2; i++) begin
         tick();
         seen |= kp.key_valid;
      end
      check("rst_deb_no_event", 32'(seen), 32'h0);
      resetn = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         tick();
         if (k == 19) check("rst_relat_before", 32'(kp.key_valid), 32'h0);
         if (k == 20) begin
            check("rst_relat_valid", 32'(kp.key_valid), 32'h1);
            check("rst_relat_code",  32'(kp.key_code),  32'd9);
         end
      end
      repeat (4) tick();
      resetn = 1'b0;
      tick();
      check_reset_outputs("rst_held");
      keys = '0;
      resetn = 1'b1;
      count_valid(60, cnt);
      check("rst_held_no_event", 32'(cnt), 32'h0);

      // Auto-repeat on code 0 (single event when repeat is not built).
      keys[0][0] = 1'b1;
      wait_valid(200, ok);
      check("rep_event", 32'(ok),          32'h1);
      check("rep_code",  32'(kp.key_code), 32'd0);
      for (int m = 1; m <= 75; m++) begin
         tick();
         exp_v = rep_en && (m == 40 || m == 50 || m == 60 || m == 70);
         check($sformatf("rep_valid_%0d", m), 32'(kp.key_valid), 32'(exp_v));
         if (exp_v) check("rep_code_same", 32'(kp.key_code), 32'd0);
      end
      check("rep_still_held", 32'(kp.key_pressed), 32'h1);
      keys = '0;
      wait_release(50, ok);
      check("rep_release", 32'(ok), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
